// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcode encodings, default
// datapath width and the issue-unit FSM state type.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLL = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue unit: 2**REG_AW entries of DATA_W bits.
// Two operand read ports and one debug read port. The operand ports forward
// same-edge writes (write-first). The debug port shows stored contents only.
// Writeback and direct load may write in the same cycle; on an address
// collision the writeback wins and the load is dropped.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREG = 1 << REG_AW;

  logic [DATA_W-1:0] r_mem [NREG];
  logic              w_ld_go;

  // Load is suppressed when the writeback targets the same entry.
  always_comb begin
    w_ld_go = ld_en & ~(wb_en & (wb_addr == ld_addr));
  end

  // Storage update: load and writeback may land on different entries together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else begin
      if (w_ld_go) r_mem[ld_addr] <= ld_data;
      if (wb_en)   r_mem[wb_addr] <= wb_data;
    end
  end

  // Operand reads with same-edge write forwarding (writeback has priority).
  always_comb begin
    rd_data1 = r_mem[rd_addr1];
    if (w_ld_go && (ld_addr == rd_addr1)) rd_data1 = ld_data;
    if (wb_en && (wb_addr == rd_addr1))   rd_data1 = wb_data;
    rd_data2 = r_mem[rd_addr2];
    if (w_ld_go && (ld_addr == rd_addr2)) rd_data2 = ld_data;
    if (wb_en && (wb_addr == rd_addr2))   rd_data2 = wb_data;
  end

  // Debug port reads stored contents directly.
  always_comb begin
    dbg_data = r_mem[dbg_addr];
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: accepts register-indexed ALU instructions over a
// valid/ready handshake, presents registered operands to an external
// combinational ALU, captures its result and writes it back.
// One instruction in flight: accept -> EXEC -> WB -> IDLE (3 cycles each).
// Optional build macro ALU_ISSUE_FLAGS_EN adds zero/negative flag outputs
// that update on each writeback.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] rs_data1,
  output logic [DATA_W-1:0] rs_data2,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] result,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  alu_state_e        r_state;
  alu_state_e        w_state_nxt;
  logic              w_accept;
  logic              w_capture;
  logic              w_wb;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  alu_regfile #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (w_wb),
    .wb_addr  (r_rd),
    .wb_data  (r_res),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rd_addr1 (instr_rs1),
    .rd_data1 (w_op1),
    .rd_addr2 (instr_rs2),
    .rd_data2 (w_op2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand, result and writeback-report registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd     <= '0;
      r_res    <= '0;
      rs_data1 <= '0;
      rs_data2 <= '0;
      alu_op   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= w_wb;
      if (w_accept) begin
        r_rd     <= instr_rd;
        rs_data1 <= w_op1;
        rs_data2 <= w_op2;
        alu_op   <= instr_op;
      end
      if (w_capture) r_res <= result;
      if (w_wb) begin
        wb_rd   <= r_rd;
        wb_data <= r_res;
      end
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  // Zero/negative flags of the most recent writeback value.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (w_wb) begin
      flag_z <= (r_res == '0);
      flag_n <= r_res[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: emulates the external ALU, drives directed
// and random stimulus, and checks against a cycle-level reference model with
// a writeback scoreboard.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] rs_data1, rs_data2;
  logic [1:0] alu_op;
  logic [7:0] result;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic       flag_z, flag_n;
`endif

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(8), .REG_AW(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rs_data1(rs_data1), .rs_data2(rs_data2), .alu_op(alu_op),
    .result(result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  // External combinational ALU seen by the unit.
  always_comb begin
    case (alu_op)
      ALU_ADD: result = rs_data1 + rs_data2;
      ALU_SUB: result = rs_data1 - rs_data2;
      ALU_SLL: result = rs_data1 << rs_data2;
      default: result = rs_data1 & rs_data2;
    endcase
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
  } wb_t;

  wb_t        sb[$];
  logic [7:0] m_reg [4];
  bit         m_pend = 0;
  int         m_pend_edge;
  logic [1:0] m_prd;
  logic [7:0] m_pval;
  bit         m_ready = 1;
  bit         m_wbv = 0;
  logic [7:0] m_rs1 = 0, m_rs2 = 0;
  logic [1:0] m_op = 0;
  bit         m_rst_seen = 0;
  bit         m_z = 0, m_n = 0;
  bit         m_acc = 0;
  int         cyc = 0;
  bit         started = 0;

  function automatic logic [7:0] ref_alu(input logic [1:0] op, input int a, input int b);
    int v;
    case (op)
      2'd0: v = (a + b) % 256;
      2'd1: v = (a - b + 256) % 256;
      2'd2: v = (b >= 8) ? 0 : (a * (1 << b)) % 256;
      default: v = a & b;
    endcase
    return v[7:0];
  endfunction

  // Apply the effect of the clock edge that just occurred, using the inputs
  // held across it.
  task automatic model_edge();
    bit wb_now;
    cyc++;
    started = 1;
    m_acc = 0;
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      m_pend = 0; m_ready = 1; m_wbv = 0;
      m_rs1 = 0; m_rs2 = 0; m_op = 0;
      m_z = 0; m_n = 0;
      sb.delete();
      m_rst_seen = 1;
    end else begin
      m_rst_seen = 0;
      wb_now = m_pend && (cyc == m_pend_edge);
      m_wbv = wb_now;
      if (wb_now) begin
        m_reg[m_prd] = m_pval;
        m_z = (m_pval == 8'h00);
        m_n = m_pval[7];
        m_pend = 0;
      end
      if (ld_en && !(wb_now && ld_addr == m_prd)) m_reg[ld_addr] = ld_data;
      if (instr_valid && m_ready) begin
        wb_t e;
        m_rs1 = m_reg[instr_rs1];
        m_rs2 = m_reg[instr_rs2];
        m_op = instr_op;
        m_pval = ref_alu(instr_op, int'(m_rs1), int'(m_rs2));
        m_prd = instr_rd;
        m_pend = 1;
        m_pend_edge = cyc + 2;
        e.rd = instr_rd; e.val = m_pval;
        sb.push_back(e);
        m_acc = 1;
      end
      m_ready = !m_pend;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("instr_ready", instr_ready, m_ready);
      chk("wb_valid", wb_valid, m_wbv);
      if (wb_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no writeback", wb_rd, wb_data);
        end else begin
          wb_t e;
          e = sb.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.val);
        end
      end
      chk("rs_data1", rs_data1, m_rs1);
      chk("rs_data2", rs_data2, m_rs2);
      chk("alu_op", alu_op, m_op);
      chk("dbg_data", dbg_data, m_reg[dbg_addr]);
      if (m_rst_seen) begin
        chk("wb_rd_rst", wb_rd, 0);
        chk("wb_data_rst", wb_data, 0);
      end
`ifdef ALU_ISSUE_FLAGS_EN
      chk("flag_z", flag_z, m_z);
      chk("flag_n", flag_n, m_n);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic drv(input logic v, input logic [1:0] op, rd, rs1, rs2,
                     input logic ld, input logic [1:0] la, input logic [7:0] ldd,
                     input logic r, input logic [1:0] dbg);
    instr_valid = v; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    ld_en = ld; ld_addr = la; ld_data = ldd; rst = r; dbg_addr = dbg;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'($urandom));
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    drv(0, 0, 0, 0, 0, 1, a, d, 0, 2'($urandom));
  endtask

  task automatic issue(input logic [1:0] op, rd, rs1, rs2);
    drv(1, op, rd, rs1, rs2, 0, 0, 0, 0, 2'($urandom));
  endtask

  // Directed register peek against a fixed expected constant.
  task automatic peek(input string nm, input logic [1:0] a, input logic [7:0] exp);
    instr_valid = 0; ld_en = 0; rst = 0; dbg_addr = a;
    @(negedge clk);
    chk(nm, dbg_data, exp);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [1:0] bop [4];
    logic [1:0] brd [4];
    logic [1:0] bs1 [4];
    logic [1:0] bs2 [4];
    int idx, guard;

    // Reset
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // ADD r3 = r1 + r2
    load(1, 8'd10); load(2, 8'd5);
    issue(ALU_ADD, 3, 1, 2);
    idle(3);
    peek("add_r3", 3, 8'h0F);

    // SUB with wrap
    load(1, 8'd20); load(2, 8'd8);
    issue(ALU_SUB, 0, 1, 2); idle(3);
    peek("sub_r0", 0, 8'h0C);
    issue(ALU_SUB, 0, 2, 1); idle(3);
    peek("sub_wrap_r0", 0, 8'hF4);

    // SLL with rd == rs1, then AND
    load(1, 8'd8); load(2, 8'd2);
    issue(ALU_SLL, 1, 1, 2); idle(3);
    peek("sll_r1", 1, 8'h20);
    issue(ALU_AND, 3, 1, 1); idle(3);
    peek("and_self_r3", 3, 8'h20);
    load(1, 8'd15); load(2, 8'd10);
    issue(ALU_AND, 3, 1, 2); idle(3);
    peek("and_r3", 3, 8'h0A);

    // Back-to-back with instr_valid held high; each reads the previous rd
    bop = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_SLL};
    brd = '{2'd0, 2'd1, 2'd2, 2'd3};
    bs1 = '{2'd1, 2'd0, 2'd1, 2'd2};
    bs2 = '{2'd2, 2'd0, 2'd0, 2'd3};
    load(3, 8'd1);
    idx = 0; guard = 0;
    while (idx < 4 && guard < 40) begin
      drv(1, bop[idx], brd[idx], bs1[idx], bs2[idx], 0, 0, 0, 0, 2'($urandom));
      if (m_acc) idx++;
      guard++;
    end
    chk("b2b_accepted", idx, 4);
    idle(3);
    chk("b2b_drained", sb.size(), 0);

    // Load/writeback collision on r3
    load(1, 8'd3); load(2, 8'd4);
    issue(ALU_ADD, 3, 1, 2);
    idle(1);
    drv(0, 0, 0, 0, 0, 1, 3, 8'h55, 0, 3);
    peek("collision_r3", 3, 8'h07);

    // Zero result for flags
    load(1, 8'd7); load(2, 8'd7);
    issue(ALU_SUB, 0, 1, 2); idle(3);
    peek("zero_r0", 0, 8'h00);

    // Reset during EXEC abandons the instruction
    issue(ALU_ADD, 2, 1, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int a = 0; a < 4; a++) peek("rst_clear", 2'(a), 8'h00);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drv(logic'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom),
          2'($urandom), logic'($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom),
          logic'($urandom_range(0, 59) == 0), 2'($urandom));
    end
    idle(4);
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
